// File: rtl/inst_mem_sync.sv
// rtl/inst_mem_sync.sv - synchronous-read byte-organised instruction memory with valid/ready fetch port
//
// Purpose: program storage for the fetch stage. A fetch request is accepted
// when req_ready is high, and the assembled word (or an error) appears in the
// response register after the next rising edge. Storage is written a byte at a
// time through the programming port, which takes priority over fetch.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        fetch request handshake
//   req_addr[31:0]             byte address of the instruction
//   rsp_valid/rsp_ready        response handshake
//   rsp_data[31:0], rsp_err    fetched word, fault flag (misaligned or out of range)
//   flush                      drop held response, block acceptance this cycle
//   prog_en/prog_addr/prog_data byte write into storage
//   fetch_cnt[31:0]            count of consumed non-error responses

module inst_mem_sync #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'hBFC00000,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter              INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    input  logic                  flush,
    input  logic                  prog_en,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [7:0]            prog_data,
    output logic [31:0]           fetch_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // First offset whose 4-byte window would run past the last byte.
    localparam logic [32:0] LIMIT = (33'd1 << ADDR_WIDTH) - 33'd3;

    logic [7:0]  mem_q [DEPTH];

    logic        rsp_valid_q;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] fetch_cnt_q;

    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  accept;
    logic [7:0]            b0, b1, b2, b3;

    // Addresses below the base wrap to huge offsets and fall out of range.
    assign offset = req_addr - BASE_ADDR;
    assign idx    = offset[ADDR_WIDTH-1:0];

    assign req_ready = rst_n & ~prog_en & ~flush & (~rsp_valid_q | rsp_ready);
    assign accept    = req_valid & req_ready;

    always_comb begin
        b0 = mem_q[idx];
        b1 = mem_q[idx + ADDR_WIDTH'(1)];
        b2 = mem_q[idx + ADDR_WIDTH'(2)];
        b3 = mem_q[idx + ADDR_WIDTH'(3)];
        rsp_err_d  = (req_addr[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);
        rsp_data_d = 32'd0;
        if (!rsp_err_d) begin
            if (BIG_ENDIAN) begin
                rsp_data_d = {b0, b1, b2, b3};
            end else begin
                rsp_data_d = {b3, b2, b1, b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            if (prog_en) begin
                mem_q[prog_addr] <= prog_data;
            end
            if (rsp_valid_q && rsp_ready && !rsp_err_q && !flush) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            // accept already excludes flush, so flush wins outright here.
            if (flush) begin
                rsp_valid_q <= 1'b0;
            end else if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rsp_data_d;
                rsp_err_q   <= rsp_err_d;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule
